// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM-like to AXI bridge: FSM states,
// fixed AXI field values, and the byte-strobe helper.
package axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;

    // Size 3 is not a legal SRAM-like transfer; it falls back to a full word.
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << addr_lo;
            2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sramlike_axi_bridge.sv
// Merges the instruction and data SRAM-like buses onto one AXI master port,
// one single-beat transaction in flight at a time.
module sramlike_axi_bridge
    import axi_pkg::*;
#(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state, state_n;
    logic        owner_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done, aw_done_n;
    logic        w_done, w_done_n;

    logic        data_pick, inst_pick;
    logic        grant;
    logic        grant_wr;
    logic        xfer_done;

    // Responses carry no information the bridge acts on: one transaction
    // in flight makes the IDs redundant and errors are not reported.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    always_comb begin
        if (DATA_PRIO != 0) begin
            data_pick = data_req;
            inst_pick = inst_req & ~data_req;
        end else begin
            data_pick = data_req & ~inst_req;
            inst_pick = inst_req;
        end
    end

    assign grant_wr = data_pick ? data_wr : inst_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (grant) begin
                owner_q <= data_pick;
                wr_q    <= grant_wr;
                size_q  <= data_pick ? data_size  : inst_size;
                addr_q  <= data_pick ? data_addr  : inst_addr;
                wdata_q <= data_pick ? data_wdata : inst_wdata;
            end
        end
    end

    always_comb begin
        state_n      = state;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        grant        = 1'b0;
        xfer_done    = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        case (state)
            IDLE: begin
                if (!reset) begin
                    data_addr_ok = data_pick;
                    inst_addr_ok = inst_pick;
                    grant        = data_pick | inst_pick;
                end
                if (grant) begin
                    state_n = grant_wr ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_n = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    xfer_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            WR_ADDR: begin
                // AW and W complete independently; the flags remember which
                // handshake already happened so its valid stays low.
                awvalid   = ~aw_done;
                wvalid    = ~w_done;
                aw_done_n = aw_done | awready;
                w_done_n  = w_done | wready;
                if (aw_done_n && w_done_n) begin
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    xfer_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign inst_data_ok = xfer_done & ~owner_q & ~reset;
    assign data_data_ok = xfer_done &  owner_q & ~reset;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = {3'b000, owner_q};
    assign araddr  = addr_q;
    assign arlen   = LEN_SINGLE;
    assign arsize  = {1'b0, size_q};
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign awid    = {3'b000, owner_q};
    assign awaddr  = addr_q;
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, size_q};
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    assign wid   = {3'b000, owner_q};
    assign wdata = wdata_q;
    assign wstrb = wr_q ? size_to_wstrb(size_q, addr_q[1:0]) : 4'b1111;
    assign wlast = 1'b1;

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench for sramlike_axi_bridge: scenario tasks drive both buses
// and a hand-driven AXI slave; a scoreboard matches every data_ok to its grant.
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 0, awready = 0, wready = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic        rlast = 1, rvalid = 0, bvalid = 0;

    typedef struct {
        bit          owner;
        bit          is_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sramlike_axi_bridge #(.DATA_PRIO(1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Scoreboard: every data_ok must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            exp_t e;
            checks++;
            if (inst_data_ok && data_data_ok) begin
                $display("FAIL sb_both_ok: got both data_ok high, required one");
            end else if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got data_ok (inst=%b data=%b), required none",
                         inst_data_ok, data_data_ok);
            end else begin
                e = sb.pop_front();
                if ({data_data_ok, rready} !== {e.owner, e.is_rd})
                    $display("FAIL sb_owner_kind: got owner=%b rd=%b, required owner=%b rd=%b",
                             data_data_ok, rready, e.owner, e.is_rd);
                else if (e.is_rd && (e.owner ? data_rdata : inst_rdata) !== e.rdata)
                    $display("FAIL sb_rdata: got %h, required %h",
                             e.owner ? data_rdata : inst_rdata, e.rdata);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        inst_req = 0; data_req = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    endtask

    task automatic test_reset();
        tick(); inst_req = 1; data_req = 1; sample();
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
            $display("FAIL reset_ok: got %b, required 0000",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else passes++;
        tick(); sample();
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0)
            $display("FAIL reset_valids: got %b, required 00000",
                     {arvalid, awvalid, wvalid, rready, bready});
        else passes++;
        tick(); reset = 0; idle_bus(); sample();
    endtask

    task automatic test_inst_read();
        tick();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000;
        sample();
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL rd_grant: got %b, required 10", {inst_addr_ok, data_addr_ok});
        else passes++;
        sb.push_back('{owner: 1'b0, is_rd: 1'b1, rdata: 32'h3C08_BFC0});
        tick(); inst_req = 0; arready = 1; sample();
        checks++;
        if ({arvalid, araddr, arid, arsize, arlen, arburst} !==
            {1'b1, 32'hBFC0_0000, 4'd0, 3'd2, 8'd0, 2'b01})
            $display("FAIL rd_ar: got v=%b a=%h id=%h sz=%h len=%h b=%b",
                     arvalid, araddr, arid, arsize, arlen, arburst);
        else passes++;
        tick(); arready = 0; rvalid = 1; rdata = 32'h3C08_BFC0; sample();
        checks++;
        if ({rready, inst_data_ok, inst_rdata} !== {1'b1, 1'b1, 32'h3C08_BFC0})
            $display("FAIL rd_resp: got rready=%b ok=%b rdata=%h, required 1 1 3c08bfc0",
                     rready, inst_data_ok, inst_rdata);
        else passes++;
        tick(); rvalid = 0; sample();
        checks++;
        if ({rready, arvalid, inst_data_ok} !== 3'b0)
            $display("FAIL rd_idle: got %b, required 000", {rready, arvalid, inst_data_ok});
        else passes++;
    endtask

    task automatic test_byte_write();
        tick();
        data_req = 1; data_wr = 1; data_size = 0;
        data_addr = 32'h8000_1003; data_wdata = 32'hAA00_0000;
        sample();
        checks++;
        if (data_addr_ok !== 1'b1)
            $display("FAIL wr_grant: got %b, required 1", data_addr_ok);
        else passes++;
        sb.push_back('{owner: 1'b1, is_rd: 1'b0, rdata: '0});
        tick(); data_req = 0; awready = 1; wready = 1; sample();
        checks++;
        if ({awvalid, wvalid, awaddr, awsize, awid, wid, wstrb, wdata, wlast} !==
            {1'b1, 1'b1, 32'h8000_1003, 3'd0, 4'd1, 4'd1, 4'b1000, 32'hAA00_0000, 1'b1})
            $display("FAIL wr_aw_w: got av=%b wv=%b a=%h sz=%h id=%h wid=%h strb=%b d=%h",
                     awvalid, wvalid, awaddr, awsize, awid, wid, wstrb, wdata);
        else passes++;
        tick(); awready = 0; wready = 0; bvalid = 1; sample();
        checks++;
        if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0011)
            $display("FAIL wr_resp: got %b, required 0011",
                     {awvalid, wvalid, bready, data_data_ok});
        else passes++;
        tick(); bvalid = 0; data_wr = 0; sample();
        checks++;
        if ({bready, data_data_ok} !== 2'b0)
            $display("FAIL wr_idle: got %b, required 00", {bready, data_data_ok});
        else passes++;
    endtask

    task automatic test_priority();
        tick();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h0000_0100;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0200;
        sample();
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL prio_grant: got data=%b inst=%b, required 1 0",
                     data_addr_ok, inst_addr_ok);
        else passes++;
        sb.push_back('{owner: 1'b1, is_rd: 1'b1, rdata: 32'hD00D_0001});
        tick(); data_req = 0; arready = 1; sample();
        checks++;
        if ({inst_addr_ok, araddr, arid} !== {1'b0, 32'h0000_0200, 4'd1})
            $display("FAIL prio_ar: got ok=%b a=%h id=%h", inst_addr_ok, araddr, arid);
        else passes++;
        tick(); arready = 0; rvalid = 1; rdata = 32'hD00D_0001; sample();
        checks++;
        if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100)
            $display("FAIL prio_dok: got %b, required 100",
                     {data_data_ok, inst_data_ok, inst_addr_ok});
        else passes++;
        tick(); rvalid = 0; sample();
        checks++;
        if (inst_addr_ok !== 1'b1)
            $display("FAIL prio_inst_grant: got %b, required 1", inst_addr_ok);
        else passes++;
        sb.push_back('{owner: 1'b0, is_rd: 1'b1, rdata: 32'h1357_9BDF});
        tick(); inst_req = 0; arready = 1; sample();
        checks++;
        if ({araddr, arid} !== {32'h0000_0100, 4'd0})
            $display("FAIL prio_ar2: got a=%h id=%h, required 00000100 0", araddr, arid);
        else passes++;
        tick(); arready = 0; rvalid = 1; rdata = 32'h1357_9BDF; sample();
        tick(); rvalid = 0; sample();
    endtask

    task automatic test_wready_delay();
        tick();
        data_req = 1; data_wr = 1; data_size = 1;
        data_addr = 32'h0000_4002; data_wdata = 32'h5566_0000;
        sample();
        sb.push_back('{owner: 1'b1, is_rd: 1'b0, rdata: '0});
        tick(); data_req = 0; awready = 1; wready = 0; sample();
        checks++;
        if ({awvalid, wvalid, wstrb, awsize} !== {1'b1, 1'b1, 4'b1100, 3'd1})
            $display("FAIL wd_c1: got av=%b wv=%b strb=%b sz=%h", awvalid, wvalid, wstrb, awsize);
        else passes++;
        for (int c = 2; c <= 3; c++) begin
            tick(); awready = 0; sample();
            checks++;
            if ({awvalid, wvalid, bready, wdata} !== {1'b0, 1'b1, 1'b0, 32'h5566_0000})
                $display("FAIL wd_hold c%0d: got av=%b wv=%b br=%b d=%h",
                         c, awvalid, wvalid, bready, wdata);
            else passes++;
        end
        tick(); wready = 1; sample();
        checks++;
        if ({awvalid, wvalid, wstrb} !== {1'b0, 1'b1, 4'b1100})
            $display("FAIL wd_c4: got av=%b wv=%b strb=%b", awvalid, wvalid, wstrb);
        else passes++;
        tick(); wready = 0; sample();
        checks++;
        if ({wvalid, bready, data_data_ok} !== 3'b010)
            $display("FAIL wd_c5: got %b, required 010", {wvalid, bready, data_data_ok});
        else passes++;
        tick(); bvalid = 1; sample();
        tick(); bvalid = 0; data_wr = 0; sample();
    endtask

    task automatic test_ar_stall();
        tick();
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1FC0_0040;
        sample();
        sb.push_back('{owner: 1'b0, is_rd: 1'b1, rdata: 32'hCAFE_F00D});
        for (int c = 1; c <= 5; c++) begin
            tick();
            inst_addr = 32'h0000_0ABC; data_req = 1; data_addr = 32'h0000_0DEF;
            sample();
            checks++;
            if ({arvalid, araddr, inst_addr_ok, data_addr_ok} !==
                {1'b1, 32'h1FC0_0040, 1'b0, 1'b0})
                $display("FAIL stall c%0d: got v=%b a=%h iok=%b dok=%b",
                         c, arvalid, araddr, inst_addr_ok, data_addr_ok);
            else passes++;
        end
        tick(); inst_req = 0; data_req = 0; arready = 1; sample();
        tick(); arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; sample();
        tick(); rvalid = 0; sample();
    endtask

    task automatic test_reset_mid();
        tick();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0800;
        sample();
        tick(); data_req = 0; arready = 1; sample();
        tick(); arready = 0; reset = 1; sample();
        checks++;
        if ({rready, data_data_ok} !== 2'b10)
            $display("FAIL rst_mid_pre: got %b, required 10", {rready, data_data_ok});
        else passes++;
        tick(); reset = 0; sample();
        checks++;
        if ({rready, arvalid, data_data_ok} !== 3'b0)
            $display("FAIL rst_mid_post: got %b, required 000", {rready, arvalid, data_data_ok});
        else passes++;
        tick(); rvalid = 1; rdata = 32'hBAD0_BAD0; sample();
        checks++;
        if ({rready, data_data_ok, inst_data_ok} !== 3'b0)
            $display("FAIL rst_mid_stray: got %b, required 000",
                     {rready, data_data_ok, inst_data_ok});
        else passes++;
        tick(); rvalid = 0; sample();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_byte_write();
        test_priority();
        test_wready_delay();
        test_ar_stall();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sramlike_axi_bridge.md
# sramlike_axi_bridge

Converts the two SRAM-like buses leaving `mycpu` into a single AXI3/AXI4 master port, sitting directly downstream of it (the instruction bus and the data bus, each already muxed between the cache and the uncached path). It has one transaction outstanding at a time and uses single-beat bursts only. Data-side requests take priority over instruction-side requests. Both SRAM-like handshakes (`addr_ok` / `data_ok`) are generated here from the AXI channel handshakes.

## Interface
- `DATA_PRIO`, default 1: 1 means the data bus wins simultaneous requests; 0 means the instruction bus wins.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req`/`inst_wr`/`inst_size`/`inst_addr`/`inst_wdata` in 1/1/2/32/32: instruction SRAM-like request.
- `inst_rdata`/`inst_addr_ok`/`inst_data_ok` out 32/1/1: instruction SRAM-like response.
- `data_req`/`data_wr`/`data_size`/`data_addr`/`data_wdata` in 1/1/2/32/32: data SRAM-like request.
- `data_rdata`/`data_addr_ok`/`data_data_ok` out 32/1/1: data SRAM-like response.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arlock`/`arcache`/`arprot`/`arvalid` out 4/32/8/3/2/2/4/3/1; `arready` in 1: AR channel.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid` in 4/32/2/1/1; `rready` out 1: R channel.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awlock`/`awcache`/`awprot`/`awvalid` out 4/32/8/3/2/2/4/3/1; `awready` in 1: AW channel.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid` out 4/32/4/1/1; `wready` in 1: W channel.
- `bid`/`bresp`/`bvalid` in 4/2/1; `bready` out 1: B channel.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE grant rule:
  - `data_addr_ok = IDLE & data_req`.
  - `inst_addr_ok = IDLE & inst_req & ~data_req`.
  - With `DATA_PRIO=0` the two roles swap.
- On a grant, latch owner (0 = inst, 1 = data), wr, size, addr, and wdata. Go to RD_ADDR if wr=0, WR_ADDR if wr=1.
- RD_ADDR: `arvalid=1`. On `arready`, go to RD_DATA.
- RD_DATA: `rready=1`. On `rvalid`, pulse the owner's `data_ok` for that cycle with `*_rdata = rdata` (combinational pass-through), then go to IDLE.
- WR_ADDR: `awvalid` and `wvalid` both rise on entry.
  - Each drops independently after its own handshake; two done-flags track this.
  - Go to WR_RESP once both are done. Both may complete in the same cycle.
- WR_RESP: `bready=1`. On `bvalid`, pulse the owner's `data_ok`, then go to IDLE.
- Constant fields:
  - `arlen`/`awlen` = 0, `arburst`/`awburst` = 2'b01, `wlast` = 1, lock/cache/prot = 0.
  - IDs = {3'b0, owner}.
- `arsize`/`awsize` = {1'b0, size}.
- Address: `araddr`/`awaddr` = latched addr, unmodified.
- `wstrb` by size:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1], 1'b0}.
  - size 2: 4'b1111.
  - size 3: illegal; drives 4'b1111.
- `rresp`/`bresp` are ignored; errors are not reported.
- `rid`/`bid` are not checked, since only one transaction is in flight.
- The non-owner's `addr_ok` and `data_ok` stay 0 during a transaction.

## Timing
- Reset values: state=IDLE; all valids, `rready`, `bready`, done-flags, and `*_data_ok` = 0; latched registers = 0.
- The `*_addr_ok` outputs are combinational from `req` in IDLE. They are 0 in every other state, including the reset cycle.
- Minimum read latency: grant in cycle 0, `arvalid` in cycle 1.
  - If `arready` is high in cycle 1 and `rvalid` in cycle 2, `data_ok` pulses in cycle 2.
  - The next grant is possible in cycle 3.
- Minimum write latency: grant in cycle 0, AW+W handshake in cycle 1, `bvalid` in cycle 2 gives `data_ok` in cycle 2.
- `data_ok` is exactly one cycle per granted request, and requests complete in grant order.
- Valids are held until their ready arrives. Address, data, and strobe stay stable while their valid is high.
- Reset mid-transaction: everything returns to IDLE on the next edge and no `data_ok` is issued. This is acceptable because reset is system-wide.
- A `req` that drops before its grant is simply not served.

## Structure
- The shared package `axi_pkg` holds:
  - the state enum;
  - AXI constants: BURST_INCR, LEN_SINGLE, ID_INST=0, ID_DATA=1;
  - the function `size_to_wstrb(size, addr[1:0])`.
- Single module, no sub-module. The `wstrb` function lives in the package so a future write-buffer can share it.

## Test plan
- Inst read at 0xBFC00000; slave gives `arready` in cycle 1 and `rvalid` with rdata=0x3C08BFC0 in cycle 2 -> `inst_data_ok`=1 in cycle 2, `inst_rdata`=0x3C08BFC0, `arid`=0, `arsize`=2.
- Byte write at 0x80001003, wdata 0xAA000000 -> `wstrb`=4'b1000, `awsize`=0, `awid`=1. `data_data_ok` pulses in the `bvalid` cycle.
- `inst_req` and `data_req` high together in IDLE -> `data_addr_ok`=1 and `inst_addr_ok`=0. The inst request is granted in the first IDLE cycle after `data_data_ok`.
- Write with `awready` in cycle 1 but `wready` delayed to cycle 4 -> `awvalid` falls after cycle 1 and `wvalid` is held through cycle 4. WR_RESP is entered in cycle 5.
- `arready` stalled for 5 cycles -> `arvalid`/`araddr` stay stable, and `addr_ok` stays 0 for both buses throughout.
- `reset` asserted in RD_DATA before `rvalid` -> next cycle state=IDLE, `rready`=0, and no `data_ok` ever fires for that request.
